// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter among NREQ byte streams.
// A granted requester keeps the transmitter until its last byte transfers or it stays idle too long.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 1023,
    localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW     = $clog2(TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic               tx_valid,
    output logic [DW-1:0]      tx_data,
    input  logic               tx_ready,
    output logic [GW-1:0]      grant_id,
    output logic               busy,
    output logic               timeout_evt
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state;
    state_t          state_next;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   sel;
    logic [CW-1:0]   idle_cnt;
    logic            xfer;
    logic            timeout_hit;

    assign xfer        = (state == XFER) && req_valid[grant_id] && tx_ready;
    assign timeout_hit = (state == XFER) && !xfer && (idle_cnt == CW'(TIMEOUT));

    // Search starts just after the previous winner so a winner waits for every other requester
    always_comb begin
        logic          found;
        logic [GW-1:0] cand;
        int            idx;
        sel   = last_grant;
        found = 1'b0;
        cand  = '0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx  = (int'(last_grant) + k) % NREQ;
            cand = GW'(idx);
            if (!found && req_valid[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if ((xfer && req_last[grant_id]) || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_id   <= '0;
            last_grant <= GW'(NREQ - 1);
            idle_cnt   <= '0;
        end else begin
            if (state == IDLE) begin
                if (|req_valid) begin
                    grant_id <= sel;
                    idle_cnt <= '0;
                end
            end else if (xfer) begin
                idle_cnt <= '0;
                if (req_last[grant_id]) begin
                    last_grant <= grant_id;
                end
            end else if (timeout_hit) begin
                last_grant <= grant_id;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        busy        = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = '0;
        req_ready   = '0;
        timeout_evt = 1'b0;
        if (state == XFER) begin
            busy                = 1'b1;
            tx_valid            = req_valid[grant_id];
            tx_data             = req_data[int'(grant_id)*DW +: DW];
            req_ready[grant_id] = tx_ready;
            timeout_evt         = timeout_hit;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a per-cycle vector table plus hand-written
// sequences for timeout, transfer-beats-timeout and reset in the middle of a packet.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 8;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_valid;
    logic [DW-1:0]     tx_data;
    logic              tx_ready;
    logic [1:0]        grant_id;
    logic              busy;
    logic              timeout_evt;

    int tests = 0;
    int fails = 0;

    uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .grant_id(grant_id),
        .busy(busy),
        .timeout_evt(timeout_evt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        rdy;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic [3:0]  e_rr;
        logic        e_busy;
        logic [1:0]  e_gid;
        logic        e_to;
    } vec_t;

    vec_t vecs[27];

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d,
                                 input logic [3:0] l, input logic r);
        req_valid = v;
        req_data  = d;
        req_last  = l;
        tx_ready  = r;
    endtask

    task automatic checkOutput(input string name, input logic e_txv, input logic [7:0] e_txd,
                               input logic [3:0] e_rr, input logic e_busy,
                               input logic [1:0] e_gid, input logic e_to);
        #1;
        checkField({name, " tx_valid"},    32'(tx_valid),    32'(e_txv));
        checkField({name, " tx_data"},     32'(tx_data),     32'(e_txd));
        checkField({name, " req_ready"},   32'(req_ready),   32'(e_rr));
        checkField({name, " busy"},        32'(busy),        32'(e_busy));
        checkField({name, " grant_id"},    32'(grant_id),    32'(e_gid));
        checkField({name, " timeout_evt"}, 32'(timeout_evt), 32'(e_to));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        // Round-robin over four 1-byte packets, then a 2-byte packet from requester 2,
        // then a backpressured 3-byte packet from requester 3 with requester 0 waiting.
        vecs[0]  = '{4'b1111, 32'h13121110, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{4'b1111, 32'h13121110, 4'b1111, 1'b1, 1'b1, 8'h10, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[2]  = '{4'b1111, 32'h13121110, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[3]  = '{4'b1111, 32'h13121110, 4'b1111, 1'b1, 1'b1, 8'h11, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[4]  = '{4'b1111, 32'h13121110, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[5]  = '{4'b1111, 32'h13121110, 4'b1111, 1'b1, 1'b1, 8'h12, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[6]  = '{4'b1111, 32'h13121110, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2, 1'b0};
        vecs[7]  = '{4'b1111, 32'h13121110, 4'b1111, 1'b1, 1'b1, 8'h13, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[8]  = '{4'b1111, 32'h13121110, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3, 1'b0};
        vecs[9]  = '{4'b1111, 32'h13121110, 4'b1111, 1'b1, 1'b1, 8'h10, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[10] = '{4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[11] = '{4'b0100, 32'h00550000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[12] = '{4'b0100, 32'h00550000, 4'b0000, 1'b1, 1'b1, 8'h55, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[13] = '{4'b0100, 32'h00A30000, 4'b0100, 1'b1, 1'b1, 8'hA3, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[14] = '{4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2, 1'b0};
        vecs[15] = '{4'b1001, 32'h310000EE, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2, 1'b0};
        vecs[16] = '{4'b1001, 32'h310000EE, 4'b0000, 1'b1, 1'b1, 8'h31, 4'b1000, 1'b1, 2'd3, 1'b0};
        for (int i = 17; i <= 21; i++) begin
            vecs[i] = '{4'b1001, 32'h320000EE, 4'b0000, 1'b0, 1'b1, 8'h32, 4'b0000, 1'b1, 2'd3, 1'b0};
        end
        vecs[22] = '{4'b1001, 32'h320000EE, 4'b0000, 1'b1, 1'b1, 8'h32, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[23] = '{4'b1001, 32'h330000EE, 4'b1000, 1'b1, 1'b1, 8'h33, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[24] = '{4'b0001, 32'h000000EE, 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3, 1'b0};
        vecs[25] = '{4'b0001, 32'h000000EE, 4'b0001, 1'b1, 1'b1, 8'hEE, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[26] = '{4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0};

        reset = 1'b0;
        applyStimulus(4'($urandom), $urandom, 4'($urandom), 1'($urandom));
        checkOutput("reset", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0);
        tick();
        tick();
        reset = 1'b1;

        for (int i = 0; i < 27; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_txv, vecs[i].e_txd, vecs[i].e_rr,
                        vecs[i].e_busy, vecs[i].e_gid, vecs[i].e_to);
            tick();
        end

        // Requester 1 sends one non-last byte then goes quiet; requester 2 is waiting
        applyStimulus(4'b0010, 32'h00007700, 4'b0000, 1'b1);
        checkOutput("to_idle", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0);
        tick();
        checkOutput("to_byte", 1'b1, 8'h77, 4'b0010, 1'b1, 2'd1, 1'b0);
        tick();
        applyStimulus(4'b0100, 32'h00880000, 4'b0100, 1'b1);
        for (int k = 0; k <= TIMEOUT; k++) begin
            checkOutput($sformatf("to_wait%0d", k), 1'b0, 8'h00, 4'b0010, 1'b1, 2'd1,
                        (k == TIMEOUT) ? 1'b1 : 1'b0);
            tick();
        end
        applyStimulus(4'b0100, 32'h00880000, 4'b0000, 1'b0);
        checkOutput("to_release", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1, 1'b0);
        tick();

        // A transfer on the cycle the counter reaches TIMEOUT keeps the grant
        for (int k = 0; k < TIMEOUT; k++) begin
            checkOutput($sformatf("win_stall%0d", k), 1'b1, 8'h88, 4'b0000, 1'b1, 2'd2, 1'b0);
            tick();
        end
        applyStimulus(4'b0100, 32'h00880000, 4'b0000, 1'b1);
        checkOutput("win_xfer", 1'b1, 8'h88, 4'b0100, 1'b1, 2'd2, 1'b0);
        tick();
        applyStimulus(4'b0100, 32'h00890000, 4'b0100, 1'b1);
        checkOutput("win_kept", 1'b1, 8'h89, 4'b0100, 1'b1, 2'd2, 1'b0);
        tick();
        applyStimulus(4'b0000, 32'h00000000, 4'b0000, 1'b1);
        checkOutput("win_done", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2, 1'b0);
        tick();

        // Reset while requester 3 presents byte 2; afterwards requester 0 wins again
        applyStimulus(4'b1001, 32'hA10000C0, 4'b0000, 1'b1);
        checkOutput("rst_idle", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2, 1'b0);
        tick();
        checkOutput("rst_b1", 1'b1, 8'hA1, 4'b1000, 1'b1, 2'd3, 1'b0);
        tick();
        applyStimulus(4'b1001, 32'hA20000C0, 4'b0000, 1'b1);
        checkOutput("rst_b2", 1'b1, 8'hA2, 4'b1000, 1'b1, 2'd3, 1'b0);
        reset = 1'b0;
        checkOutput("rst_async", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0);
        tick();
        reset = 1'b1;
        checkOutput("rst_after", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0);
        tick();
        checkOutput("rst_regrant", 1'b1, 8'hC0, 4'b0001, 1'b1, 2'd0, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares the single UART transmitter among NREQ requesters (MCAC channel status/debug sources). Each requester presents bytes on a valid/ready stream with an end-of-packet flag. Once granted, a requester keeps the transmitter until its last byte is accepted or an inactivity timeout expires. The block sits between the requester streams and the UART TX byte interface inside `uart`.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, byte width
- TIMEOUT, 1023, idle cycles tolerated inside a granted packet before forced release (≥1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  per-requester byte valid
- req_data  input  NREQ*DW  per-requester byte; requester i uses bits [i*DW +: DW]
- req_last  input  NREQ  byte is last of packet
- req_ready  output  NREQ  byte accepted when valid&ready
- tx_valid  output  1  byte to UART transmitter
- tx_data  output  DW  byte to transmitter
- tx_ready  input  1  transmitter accepts byte
- grant_id  output  $clog2(NREQ)  current/last granted requester
- busy  output  1  high in XFER
- timeout_evt  output  1  one-cycle pulse on forced release

## Operation
- States: IDLE, XFER (registered state; 1-bit encoding acceptable).
- IDLE: busy=0, tx_valid=0, req_ready=0. If any req_valid, select first set bit searching from (last_grant+1) mod NREQ upward with wrap; register grant_id, clear idle counter, go XFER.
- XFER: tx_valid = req_valid[grant_id]; tx_data = req_data[grant_id]; req_ready[grant_id] = tx_ready; all other req_ready bits 0. Combinational pass-through, no buffering.
- Transfer = tx_valid & tx_ready. On transfer: idle counter cleared. If req_last[grant_id] also high: last_grant ← grant_id, go IDLE.
- Cycles in XFER with no transfer increment idle counter (saturating, width $clog2(TIMEOUT+1)). When counter == TIMEOUT and no transfer in that cycle: timeout_evt=1 for that cycle, last_grant ← grant_id, go IDLE. Transfer in the same cycle wins (no timeout).
- Non-granted requesters' valid/data/last ignored; requesters must hold data stable while valid & !ready.
- tx_data = 0 when not in XFER.
- Requester deasserting req_valid mid-packet does not release grant; only last-byte transfer or timeout does.

## Timing
- Reset (reset=0, async): state IDLE, grant_id=0, last_grant=NREQ-1 (requester 0 highest priority first), idle counter 0, req_ready=0, tx_valid=0, tx_data=0, busy=0, timeout_evt=0. Reset mid-packet aborts immediately; no byte counted as sent unless its transfer edge preceded reset assertion.
- Arbitration latency: req_valid sampled in IDLE at edge N → tx_valid high from cycle N+1.
- Byte throughput in XFER: one byte per cycle when tx_ready held high.
- Packet-to-packet: exactly one IDLE bubble cycle after last-byte transfer.
- Timeout: grant lost after TIMEOUT+1 consecutive non-transfer XFER cycles; timeout_evt on the final one.
- Simultaneous requests: resolved purely by round-robin pointer; a requester granted cannot be granted again before all other continuously-requesting requesters.
- NREQ=1: always grant 0, still one bubble between packets.

## Test plan
- Reset: reset=0 with random inputs → all outputs 0, grant_id=0; release, req_valid=4'b1111 → first grant_id=0, tx_valid at next cycle.
- Single packet: req 2 sends 0x55,0xA3(last), tx_ready=1 → tx_data 0x55 then 0xA3 on consecutive cycles, req_ready=4'b0100 in XFER, busy drops the cycle after 0xA3.
- Round-robin: all four requesting 1-byte packets continuously → grant order 0,1,2,3,0 with one IDLE cycle between each.
- Backpressure: tx_ready low 5 cycles mid-packet → tx_valid/tx_data held, no byte lost or duplicated, no timeout (TIMEOUT=1023).
- Timeout: TIMEOUT=8, req 1 sends 1 non-last byte then drops valid → timeout_evt pulse 9 cycles later, IDLE next, next grant goes to requester 2 if valid.
- Reset mid-packet: assert reset during byte 2 of 4 → outputs 0 asynchronously; after release, grant restarts from requester 0.
